uart_hex_display: RTL



---
 rtl/uart_hex_display_if.sv | 9 +
 rtl/uart_hex_display.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_hex_display_if.sv
// Byte stream from the UART receiver into the hex display, plus the error strobe back out.
interface uart_hex_display_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  modport master (output rx_data, output rx_valid, input rx_err);
  modport slave  (input rx_data, input rx_valid, output rx_err);
endinterface

// File: rtl/uart_hex_display.sv
// Eight-digit scanned common-anode 7-segment driver fed by ASCII hex bytes.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module uart_hex_display #(
  parameter logic [15:0] SCAN_DIV = 16'd50000
) (
  input  logic                    clk,
  input  logic                    rst,
  uart_hex_display_if.slave       rx,
  output logic [7:0]              en,
  output logic [7:0]              seg_data,
  output logic [3:0]              digit_cnt
);

  logic [31:0] buf_r;
  logic [3:0]  cnt_r;
  logic        rx_err_r;
  logic [15:0] div_r;
  logic [2:0]  idx_r;
  logic        load_r;
  logic [7:0]  en_r;
  logic [7:0]  seg_r;
  logic        is_hex_s;
  logic [3:0]  nib_s;
  logic        tc_s;
  logic [7:0]  blank_s;
  logic [3:0]  digit_val_s;
  logic [7:0]  seg_next_s;

  function automatic logic [7:0] encode(input logic [3:0] v);
    case (v)
      4'h0: encode = 8'hC0;
      4'h1: encode = 8'hF9;
      4'h2: encode = 8'hA4;
      4'h3: encode = 8'hB0;
      4'h4: encode = 8'h99;
      4'h5: encode = 8'h92;
      4'h6: encode = 8'h82;
      4'h7: encode = 8'hF8;
      4'h8: encode = 8'h80;
      4'h9: encode = 8'h90;
      4'hA: encode = 8'h88;
      4'hB: encode = 8'h83;
      4'hC: encode = 8'hC6;
      4'hD: encode = 8'hA1;
      4'hE: encode = 8'h86;
      4'hF: encode = 8'h8E;
      default: encode = 8'hFF;
    endcase
  endfunction

  // Classify the incoming byte as a hex digit and extract its nibble.
  always_comb begin
    is_hex_s = 1'b0;
    nib_s    = 4'h0;
    if (rx.rx_data >= 8'h30 && rx.rx_data <= 8'h39) begin
      is_hex_s = 1'b1;
      nib_s    = rx.rx_data[3:0];
    end else if ((rx.rx_data >= 8'h41 && rx.rx_data <= 8'h46) ||
                 (rx.rx_data >= 8'h61 && rx.rx_data <= 8'h66)) begin
      is_hex_s = 1'b1;
      nib_s    = rx.rx_data[3:0] + 4'd9;
    end else begin
      is_hex_s = 1'b0;
      nib_s    = 4'h0;
    end
  end

  // Digit buffer, entry count and error strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_r    <= 32'h0;
      cnt_r    <= 4'd0;
      rx_err_r <= 1'b0;
    end else begin
      rx_err_r <= 1'b0;
      if (rx.rx_valid) begin
        if (is_hex_s) begin
          buf_r <= {buf_r[27:0], nib_s};
          if (cnt_r != 4'd8) cnt_r <= cnt_r + 4'd1;
        end else if (rx.rx_data == 8'h0D) begin
          buf_r <= 32'h0;
          cnt_r <= 4'd0;
        end else if (rx.rx_data == 8'h08) begin
          if (cnt_r != 4'd0) begin
            buf_r <= {4'h0, buf_r[31:4]};
            cnt_r <= cnt_r - 4'd1;
          end
        end else begin
          rx_err_r <= 1'b1;
        end
      end
    end
  end

  assign tc_s = (div_r == (SCAN_DIV - 16'd1));

  // Free-running slot divider and digit index; load_r marks the edge the new slot is latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r  <= 16'd0;
      idx_r  <= 3'd0;
      load_r <= 1'b0;
    end else begin
      load_r <= tc_s;
      if (tc_s) begin
        div_r <= 16'd0;
        idx_r <= idx_r + 3'd1;
      end else begin
        div_r <= div_r + 16'd1;
      end
    end
  end

`ifdef SEG_LZB_EN
  // A digit is blank when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    logic nz_v;
    nz_v    = 1'b0;
    blank_s = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      nz_v       = nz_v | (buf_r[4*i +: 4] != 4'h0);
      blank_s[i] = (i != 0) && !nz_v;
    end
  end
`else
  assign blank_s = 8'h00;
`endif

  // Segment pattern for the digit currently selected by idx_r.
  always_comb begin
    digit_val_s = buf_r[{idx_r, 2'b00} +: 4];
    if (blank_s[idx_r]) begin
      seg_next_s = 8'hFF;
    end else begin
      seg_next_s = encode(digit_val_s);
    end
  end

  // Registered digit enable and segment outputs, updated once per slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_r  <= 8'hFF;
      seg_r <= 8'hFF;
    end else if (load_r) begin
      en_r  <= ~(8'h01 << idx_r);
      seg_r <= seg_next_s;
    end
  end

  assign en        = en_r;
  assign seg_data  = seg_r;
  assign digit_cnt = cnt_r;
  assign rx.rx_err = rx_err_r;

endmodule
